// File: rtl/piso_tx_ctrl_if.sv
// Parallel word handshake between a producer and piso_tx_ctrl.
//   valid : producer has a word on data
//   data  : DATA_W-bit word to transmit
//   ready : controller can accept a word this cycle
// master = producer side, slave = controller side.
interface piso_tx_ctrl_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/piso_tx_ctrl.sv
// Parallel-in/serial-out transmit controller. Accepts a word over the
// valid/ready handshake and sends it MSB-first on o_sdata, each bit held
// CLKS_PER_BIT clocks, then pulses o_done for one cycle.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus          : piso_tx_ctrl_if.slave (valid, data in; ready out)
//   o_sdata      : serial data
//   o_bit_valid  : o_sdata carries a payload/parity bit
//   o_busy       : controller not idle
//   o_done       : one-cycle pulse at the end of each word
// Optional feature: define PIS_TX_PARITY_EN to append an even parity bit
// period after the LSB.
module piso_tx_ctrl #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  piso_tx_ctrl_if.slave  bus,
  output logic           o_sdata,
  output logic           o_bit_valid,
  output logic           o_busy,
  output logic           o_done
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam int unsigned DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
`ifdef PIS_TX_PARITY_EN
    PARITY = 2'd2,
`endif
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              ready_q, ready_d;
  logic              sdata_d, bit_valid_d, busy_d, done_d;
`ifdef PIS_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign bus.ready = ready_q;

  // Next-state, datapath and next-output decode
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
`ifdef PIS_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    ready_d     = 1'b0;
    sdata_d     = 1'b0;
    bit_valid_d = 1'b0;
    busy_d      = 1'b1;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.valid && ready_q) begin
          shreg_d   = bus.data;
          bit_cnt_d = '0;
          div_cnt_d = '0;
`ifdef PIS_TX_PARITY_EN
          parity_d  = ^bus.data;
`endif
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
`ifdef PIS_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = DONE;
`endif
          end else begin
            shreg_d   = {shreg_q[DATA_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
`ifdef PIS_TX_PARITY_EN
      PARITY: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          state_d   = DONE;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered
    case (state_d)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      SHIFT: begin
        sdata_d     = shreg_d[DATA_W-1];
        bit_valid_d = 1'b1;
      end
`ifdef PIS_TX_PARITY_EN
      PARITY: begin
        sdata_d     = parity_d;
        bit_valid_d = 1'b1;
      end
`endif
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
`ifdef PIS_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
      ready_q     <= 1'b1;
      o_sdata     <= 1'b0;
      o_bit_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
`ifdef PIS_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
      ready_q     <= ready_d;
      o_sdata     <= sdata_d;
      o_bit_valid <= bit_valid_d;
      o_busy      <= busy_d;
      o_done      <= done_d;
    end
  end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Testbench for piso_tx_ctrl: two instances (CLKS_PER_BIT 4 and 1), each
// compared every cycle against a timeline model that expands each accepted
// word into its expected per-cycle outputs.
module tb_piso_tx_ctrl;

  localparam int unsigned DW = 8;
  localparam logic [4:0] IDLE_OUT = 5'b10000;  // {ready, sdata, bit_valid, busy, done}
  localparam logic [4:0] DONE_OUT = 5'b00011;

  logic clk;
  int   n_checks;
  int   n_errors;
  bit   lane_fin [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    n_checks = 0;
    n_errors = 0;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int unsigned P    = (g == 0) ? 4 : 1;
    localparam int          NCYC = (g == 0) ? 2500 : 1500;

    logic rst;
    logic sdata, bit_valid, busy, done;

    piso_tx_ctrl_if #(.DATA_W(DW)) bus ();

    piso_tx_ctrl #(.DATA_W(DW), .CLKS_PER_BIT(P)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .bus         (bus.slave),
      .o_sdata     (sdata),
      .o_bit_valid (bit_valid),
      .o_busy      (busy),
      .o_done      (done)
    );

    initial begin : drv
      logic [4:0]    exp_q [$];
      logic [4:0]    exp_cur;
      logic [DW-1:0] words [$];
      logic [DW-1:0] d;
      logic          r, v, pbit;
      int            widx, since, ndir;

      if (g == 0) begin
        words = '{8'hA5, 8'h3C, 8'hFF, 8'h0F, 8'hA5, 8'h81};
        ndir  = 6;
      end else begin
        words = '{8'h07};
        ndir  = 1;
      end
      widx      = 0;
      since     = 0;
      exp_cur   = IDLE_OUT;
      rst       = 1'b1;
      bus.valid = 1'b1;
      bus.data  = 8'hFF;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
        @(negedge clk);
        if (cyc >= 1)
          chk($sformatf("lane%0d_cyc%0d_outs", g, cyc),
              {3'b000, bus.ready, sdata, bit_valid, busy, done}, {3'b000, exp_cur});

        if (words.size() == 0) words.push_back(DW'($urandom));
        r = 1'b0;
        v = 1'b0;
        d = DW'($urandom);
        if (cyc < 2) begin
          // Reset with a word presented: must not be captured
          r = 1'b1;
          v = 1'b1;
          d = 8'hFF;
        end else if (widx < ndir) begin
          // Producer holds valid with the next word until accepted
          v = 1'b1;
          d = words[0];
          if (g == 0 && widx == 4 && since == 10) begin
            d = 8'hF0;                           // ignored while busy
          end
          if (g == 0 && widx == 5 && since == 10) r = 1'b1;  // abort 0xA5
        end else begin
          if (exp_cur[4]) begin
            v = ($urandom_range(0, 2) != 0);
            if (v) d = words[0];
          end else begin
            v = ($urandom_range(0, 3) == 0);     // junk pulses while busy
          end
          r = ($urandom_range(0, 299) == 0);
        end
        rst       = r;
        bus.valid = v;
        bus.data  = d;

        if (r) begin
          exp_q.delete();
          exp_cur = IDLE_OUT;
        end else begin
          if (exp_cur[4] && v) begin
            for (int n = 0; n < DW; n++) begin
              pbit = d[DW-1-n];
              for (int k = 0; k < P; k++) exp_q.push_back({1'b0, pbit, 3'b110});
            end
`ifdef PIS_TX_PARITY_EN
            pbit = ($countones(d) % 2) == 1;
            for (int k = 0; k < P; k++) exp_q.push_back({1'b0, pbit, 3'b110});
`endif
            exp_q.push_back(DONE_OUT);
            void'(words.pop_front());
            widx++;
            since = 0;
          end
          exp_cur = (exp_q.size() > 0) ? exp_q.pop_front() : IDLE_OUT;
        end
        since++;
      end
      lane_fin[g] = 1'b1;
    end
  end

  initial begin
    int guard;
    guard = 0;
    while (!(lane_fin[0] && lane_fin[1]) && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    chk("lanes_finished", {6'd0, lane_fin[1], lane_fin[0]}, 8'h03);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
